max7219_scheduler: RTL and testbench

MAX7219_SCHEDULER -- requirements
Module: max7219_scheduler

---
 rtl/max7219_pkg.sv | 26 ++
 rtl/max7219_scheduler_if.sv | 12 +
 rtl/max7219_dirty_arb.sv | 22 ++
 rtl/max7219_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_max7219_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/max7219_pkg.sv
// Shared constants, state encoding and frame payload for the MAX7219 update scheduler.
package max7219_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned INIT_FIXED = 5;

  localparam logic [DATA_W-1:0] REG_DECODE     = 8'h09;
  localparam logic [DATA_W-1:0] REG_INTENSITY  = 8'h0A;
  localparam logic [DATA_W-1:0] REG_SCAN_LIMIT = 8'h0B;
  localparam logic [DATA_W-1:0] REG_SHUTDOWN   = 8'h0C;
  localparam logic [DATA_W-1:0] REG_TEST       = 8'h0F;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/max7219_scheduler_if.sv
// Register-write handshake between the scheduler and the MAX7219 serializer.
interface max7219_scheduler_if;
  import max7219_pkg::*;

  logic              max_start;
  logic [DATA_W-1:0] max_addr;
  logic [DATA_W-1:0] max_din;
  logic              max_busy;

  modport master (output max_start, max_addr, max_din, input max_busy);
  modport slave  (input max_start, max_addr, max_din, output max_busy);
endinterface

// File: rtl/max7219_dirty_arb.sv
// Priority pick among pending writes: intensity first, then the lowest dirty digit.
module max7219_dirty_arb #(
  parameter int unsigned DIGIT_NUM = 8
) (
  input  logic [DIGIT_NUM-1:0] dirty,
  input  logic                 int_flag,
  output logic                 req_c,
  output logic                 sel_int_c,
  output logic [2:0]           sel_idx_c
);

  always_comb begin
    req_c     = int_flag | (|dirty);
    sel_int_c = int_flag;
    sel_idx_c = '0;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = int'(DIGIT_NUM) - 1; i >= 0; i--) begin
      if (dirty[i]) sel_idx_c = 3'(i);
    end
  end

endmodule

// File: rtl/max7219_scheduler.sv
// Schedules MAX7219 register writes: power-up sequence, then intensity/digit updates.
// Define MAX7219_SCHED_PERIODIC_REFRESH_EN to replay the power-up sequence every REFRESH_CYCLES.
module max7219_scheduler
  import max7219_pkg::*;
#(
  parameter int unsigned DIGIT_NUM      = 8,
  parameter int unsigned REFRESH_CYCLES = 1500000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       digit_we,
  input  logic [2:0]                 digit_idx,
  input  logic [DATA_W-1:0]          digit_val,
  input  logic                       intensity_we,
  input  logic [3:0]                 intensity_in,
  max7219_scheduler_if.master        ser,
  output logic                       init_done,
  output logic                       pending
);

  localparam int unsigned IDX_W     = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;
  localparam int unsigned ITEM_W    = 4;
  localparam int unsigned LAST_ITEM = INIT_FIXED + DIGIT_NUM - 1;

  state_t                state_q, state_d;
  logic [ITEM_W-1:0]     item_q, item_d;
  logic                  init_seq_q, init_seq_d;
  logic [DIGIT_NUM-1:0]  dirty_q, dirty_d, dirty_set, clr_dirty;
  logic                  int_flag_q, int_flag_d, clr_int;
  logic [3:0]            int_val_q;
  logic [DATA_W-1:0]     digit_mem [DIGIT_NUM];
  frame_t                frame_q, frame_d, init_frame, arb_frame;
  logic                  start_q;
  logic                  init_fin;
  logic                  refresh_req;
  logic                  digit_ok;
  logic                  arb_req, arb_sel_int;
  logic [2:0]            arb_sel_idx;

  assign digit_ok = digit_we && (32'(digit_idx) < DIGIT_NUM);

  always_comb begin
    dirty_set = '0;
    if (digit_ok) dirty_set[IDX_W'(digit_idx)] = 1'b1;
  end

  max7219_dirty_arb #(.DIGIT_NUM(DIGIT_NUM)) u_arb (
    .dirty     (dirty_q),
    .int_flag  (int_flag_q),
    .req_c     (arb_req),
    .sel_int_c (arb_sel_int),
    .sel_idx_c (arb_sel_idx)
  );

  // Power-up item table; items past the fixed block are the digit registers.
  always_comb begin
    init_frame = '{addr: 8'(item_q - ITEM_W'(INIT_FIXED - 1)),
                   data: digit_mem[IDX_W'(item_q - ITEM_W'(INIT_FIXED))]};
    case (item_q)
      4'd0: init_frame = '{addr: REG_SHUTDOWN,   data: 8'h01};
      4'd1: init_frame = '{addr: REG_SCAN_LIMIT, data: 8'(DIGIT_NUM - 1)};
      4'd2: init_frame = '{addr: REG_DECODE,     data: 8'hFF};
      4'd3: init_frame = '{addr: REG_TEST,       data: 8'h00};
      4'd4: init_frame = '{addr: REG_INTENSITY,  data: {4'h0, int_val_q}};
      default: ;
    endcase
  end

  always_comb begin
    if (arb_sel_int) arb_frame = '{addr: REG_INTENSITY, data: {4'h0, int_val_q}};
    else             arb_frame = '{addr: 8'(arb_sel_idx) + 8'd1,
                                   data: digit_mem[IDX_W'(arb_sel_idx)]};
  end

  always_comb begin
    state_d    = state_q;
    item_d     = item_q;
    init_seq_d = init_seq_q;
    frame_d    = frame_q;
    init_fin   = 1'b0;
    clr_int    = 1'b0;
    clr_dirty  = '0;
    case (state_q)
      INIT: begin
        if (!ser.max_busy) begin
          state_d = ISSUE;
          frame_d = init_frame;
        end
      end
      IDLE: begin
        if (refresh_req) begin
          state_d    = INIT;
          item_d     = '0;
          init_seq_d = 1'b1;
        end else if (arb_req && !ser.max_busy) begin
          state_d = ISSUE;
          frame_d = arb_frame;
          if (arb_sel_int) clr_int = 1'b1;
          else             clr_dirty[IDX_W'(arb_sel_idx)] = 1'b1;
        end
      end
      ISSUE:    if (ser.max_busy) state_d = WAIT_ACK;
      WAIT_ACK: if (ser.max_busy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!ser.max_busy) begin
          if (!init_seq_q) begin
            state_d = IDLE;
          end else if (item_q == ITEM_W'(LAST_ITEM)) begin
            state_d    = IDLE;
            init_seq_d = 1'b0;
            init_fin   = 1'b1;
          end else begin
            state_d = INIT;
            item_d  = item_q + ITEM_W'(1);
          end
        end
      end
      default: state_d = INIT;
    endcase
    // A strobe landing on the clearing cycle keeps its flag so the new value is resent.
    dirty_d    = (dirty_q & ~clr_dirty) | dirty_set;
    int_flag_d = (int_flag_q & ~clr_int) | intensity_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      item_q     <= '0;
      init_seq_q <= 1'b1;
      frame_q    <= '0;
      start_q    <= 1'b0;
      init_done  <= 1'b0;
      pending    <= 1'b1;
      dirty_q    <= '0;
      int_flag_q <= 1'b0;
      int_val_q  <= '0;
      for (int i = 0; i < int'(DIGIT_NUM); i++) digit_mem[i] <= '0;
    end else begin
      state_q    <= state_d;
      item_q     <= item_d;
      init_seq_q <= init_seq_d;
      frame_q    <= frame_d;
      start_q    <= (state_d == ISSUE);
      init_done  <= init_done | init_fin;
      pending    <= (|dirty_d) | int_flag_d | (state_d != IDLE);
      dirty_q    <= dirty_d;
      int_flag_q <= int_flag_d;
      if (intensity_we) int_val_q <= intensity_in;
      if (digit_ok) digit_mem[IDX_W'(digit_idx)] <= digit_val;
    end
  end

  assign ser.max_start = start_q;
  assign ser.max_addr  = frame_q.addr;
  assign ser.max_din   = frame_q.data;

`ifdef MAX7219_SCHED_PERIODIC_REFRESH_EN
  localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [CNT_W-1:0] refresh_cnt_q;
  logic             refresh_req_q;

  // Counter idles at 0 until the first power-up sequence finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      refresh_req_q <= 1'b0;
    end else begin
      if (!init_done || refresh_cnt_q == CNT_W'(REFRESH_CYCLES - 1)) refresh_cnt_q <= '0;
      else refresh_cnt_q <= refresh_cnt_q + CNT_W'(1);
      if (init_done && refresh_cnt_q == CNT_W'(REFRESH_CYCLES - 1)) refresh_req_q <= 1'b1;
      else if (state_q == IDLE) refresh_req_q <= 1'b0;
    end
  end

  assign refresh_req = refresh_req_q;
`else
  assign refresh_req = 1'b0;
`endif

endmodule

// File: tb/tb_max7219_scheduler.sv
// Bench for max7219_scheduler: serializer model, directed frame-order checks and a randomized
// eventual-consistency check against per-register shadow values.
module tb_max7219_scheduler;

  localparam int unsigned DN = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       digit_we = 1'b0;
  logic [2:0] digit_idx = '0;
  logic [7:0] digit_val = '0;
  logic       intensity_we = 1'b0;
  logic [3:0] intensity_in = '0;
  logic       init_done, pending;

  max7219_scheduler_if ser ();

  max7219_scheduler #(.DIGIT_NUM(DN), .REFRESH_CYCLES(200)) dut (
    .clk          (clk),
    .rst          (rst),
    .digit_we     (digit_we),
    .digit_idx    (digit_idx),
    .digit_val    (digit_val),
    .intensity_we (intensity_we),
    .intensity_in (intensity_in),
    .ser          (ser),
    .init_done    (init_done),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          busy_cnt = 0;
  logic [15:0] cap_q [$];
  logic [7:0]  mdl_digit [DN];
  logic [3:0]  mdl_int;

  // Serializer: accepts a start when idle, records the frame, stays busy 16 cycles.
  always @(negedge clk) begin
    if (busy_cnt > 0) busy_cnt--;
    else if (ser.max_start === 1'b1) begin
      cap_q.push_back({ser.max_addr, ser.max_din});
      busy_cnt = 16;
    end
    ser.max_busy = (busy_cnt > 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_frame(input string tag, input logic [7:0] ea, input logic [7:0] ed);
    int t = 0;
    logic [15:0] f;
    while (cap_q.size() == 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    f = (cap_q.size() > 0) ? cap_q.pop_front() : 16'hxxxx;
    n_cmp++;
    assert (f === {ea, ed}) else begin
      n_err++;
      $error("FAIL %s: observed frame %h, expected %h", tag, f, {ea, ed});
    end
  endtask

  task automatic expect_init(input string tag);
    next_frame($sformatf("%s_shutdown", tag), 8'h0C, 8'h01);
    next_frame($sformatf("%s_scanlim", tag), 8'h0B, 8'(DN - 1));
    next_frame($sformatf("%s_decode", tag), 8'h09, 8'hFF);
    next_frame($sformatf("%s_test", tag), 8'h0F, 8'h00);
    next_frame($sformatf("%s_intensity", tag), 8'h0A, {4'h0, mdl_int});
    for (int k = 0; k < int'(DN); k++)
      next_frame($sformatf("%s_digit%0d", tag, k), 8'(k + 1), mdl_digit[k]);
  endtask

  task automatic wait_init_done();
    int t = 0;
    while (init_done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_busy();
    int t = 0;
    while (ser.max_busy !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_quiet();
    int t = 0;
    while (!(pending === 1'b0 && ser.max_busy === 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic write_digit(input logic [2:0] idx, input logic [7:0] val);
    @(negedge clk);
    digit_we  = 1'b1;
    digit_idx = idx;
    digit_val = val;
    mdl_digit[idx] = val;
    @(negedge clk);
    digit_we = 1'b0;
  endtask

  logic [7:0] last_val [16];
  logic [7:0] written;
  logic       int_written;
  logic [7:0] a;

  initial begin
    for (int k = 0; k < int'(DN); k++) mdl_digit[k] = '0;
    mdl_int = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_start", ser.max_start, 1'b0);
    chk("rst_addr", ser.max_addr, 8'h00);
    chk("rst_din", ser.max_din, 8'h00);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_pending", pending, 1'b1);

    // Release reset while the serializer is still busy
    @(posedge clk);
    busy_cnt = 10;
    @(negedge clk);
    rst = 1'b0;
    expect_init("init");
    wait_init_done();
    chk("init_done", init_done, 1'b1);
    @(negedge clk);
    chk("init_pending", pending, 1'b0);

`ifdef MAX7219_SCHED_PERIODIC_REFRESH_EN
    expect_init("replay1");
    chk("replay1_init_done", init_done, 1'b1);
    expect_init("replay2");
    chk("replay2_init_done", init_done, 1'b1);
`else
    // Intensity beats dirty digits; last intensity wins; lowest digit next
    write_digit(3'd6, 8'h33);
    wait_busy();
    @(negedge clk);
    intensity_we = 1'b1;
    intensity_in = 4'h3;
    @(negedge clk);
    intensity_in = 4'h9;
    @(negedge clk);
    intensity_we = 1'b0;
    mdl_int = 4'h9;
    write_digit(3'd3, 8'h05);
    write_digit(3'd1, 8'h02);
    next_frame("dig6", 8'h07, 8'h33);
    next_frame("int_first", 8'h0A, 8'h09);
    next_frame("dig1_before_dig3", 8'h02, 8'h02);
    next_frame("dig3", 8'h04, 8'h05);
    wait_quiet();
    chk("quiet1_pending", pending, 1'b0);

    // Rewrite during own transfer
    write_digit(3'd0, 8'h01);
    wait_busy();
    write_digit(3'd0, 8'h07);
    next_frame("dig0_inflight", 8'h01, 8'h01);
    next_frame("dig0_resent", 8'h01, 8'h07);
    wait_quiet();

    // Reset during WAIT_DONE
    write_digit(3'd5, 8'h44);
    wait_busy();
    next_frame("pre_rst", 8'h06, 8'h44);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_start", ser.max_start, 1'b0);
    chk("midrst_init_done", init_done, 1'b0);
    chk("midrst_pending", pending, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < int'(DN); k++) mdl_digit[k] = '0;
    mdl_int = '0;
    expect_init("reinit");
    wait_init_done();
    chk("reinit_done", init_done, 1'b1);
    wait_quiet();

    // Random strobes: final frame per register must carry the last written value
    written = '0;
    int_written = 1'b0;
    for (int k = 0; k < 16; k++) last_val[k] = 'x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        intensity_we = 1'b1;
        intensity_in = 4'($urandom);
        mdl_int = intensity_in;
        int_written = 1'b1;
      end else begin
        digit_we  = 1'b1;
        digit_idx = 3'($urandom_range(0, 7));
        digit_val = 8'($urandom);
        mdl_digit[digit_idx] = digit_val;
        written[digit_idx] = 1'b1;
      end
      @(negedge clk);
      digit_we = 1'b0;
      intensity_we = 1'b0;
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    wait_quiet();
    chk("rnd_pending", pending, 1'b0);
    chk("rnd_init_done", init_done, 1'b1);
    while (cap_q.size() > 0) begin
      logic [15:0] f;
      f = cap_q.pop_front();
      a = f[15:8];
      chk("rnd_addr_valid", ((a >= 8'h01 && a <= 8'h08) || a == 8'h0A), 1'b1);
      last_val[a[3:0]] = f[7:0];
    end
    for (int k = 0; k < int'(DN); k++)
      if (written[k]) chk($sformatf("rnd_digit%0d", k), last_val[k + 1], mdl_digit[k]);
    if (int_written) chk("rnd_intensity", last_val[10], {4'h0, mdl_int});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
